// File: rtl/tdp_march_bist.sv
// tdp_march_bist: march-test initiator for a true dual-port RAM.
// Sequence: write A ascending, read B ascending, write B (inverted) descending,
// read A descending. Read data is checked one cycle after its address.
// Optional build macro TDP_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module tdp_march_bist #(
  parameter int          DATA_W = 256,
  parameter int          ADDR_W = 4,
  parameter int          DEPTH  = 9,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        fail_count,
  output logic              weA,
  output logic              weB,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0] dinA,
  output logic [DATA_W-1:0] dinB,
  input  logic [DATA_W-1:0] doutA,
  input  logic [DATA_W-1:0] doutB
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0, S_W1, S_R1, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

`ifdef TDP_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  // Address-seeded base pattern.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    pat = {(DATA_W/8){SEED}} ^ {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic                exp_inv_q, exp_inv_d;
  logic [7:0]          fail_count_q, fail_count_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   din_a_q, din_a_d, din_b_q, din_b_d;
  logic [DATA_W-1:0]   rd_data_s, exp_data_s;
  logic                mismatch_s;

  // Next-state, compare and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    cmp_valid_d  = 1'b0;
    exp_addr_d   = exp_addr_q;
    exp_inv_d    = exp_inv_q;
    fail_count_d = fail_count_q;
    fail_addr_d  = fail_addr_q;

    rd_data_s  = exp_inv_q ? doutA : doutB;
    exp_data_s = exp_inv_q ? ~pat(exp_addr_q) : pat(exp_addr_q);
    mismatch_s = cmp_valid_q && (rd_data_s != exp_data_s);

    if (mismatch_s) begin
      fail_count_d = (fail_count_q == 8'hFF) ? 8'hFF : fail_count_q + 8'd1;
      fail_addr_d  = (fail_count_q == 8'd0) ? exp_addr_q : fail_addr_q;
    end else begin
      fail_count_d = fail_count_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_W0;
          cnt_d        = {ADDR_W{1'b0}};
          drain_d      = 1'b0;
          fail_count_d = 8'd0;
          fail_addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_W0: begin
        if (cnt_q == LAST) begin
          state_d = S_R0;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_R0: begin
        if (!drain_q) begin
          cmp_valid_d = 1'b1;
          exp_addr_d  = cnt_q;
          exp_inv_d   = 1'b0;
          if (cnt_q == LAST) drain_d = 1'b1;
          else               cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          drain_d = 1'b0;
          state_d = S_W1;
          cnt_d   = LAST;
        end
      end
      S_W1: begin
        if (cnt_q == {ADDR_W{1'b0}}) begin
          state_d = S_R1;
          cnt_d   = LAST;
        end else begin
          cnt_d = cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_R1: begin
        if (!drain_q) begin
          cmp_valid_d = 1'b1;
          exp_addr_d  = cnt_q;
          exp_inv_d   = 1'b1;
          if (cnt_q == {ADDR_W{1'b0}}) drain_d = 1'b1;
          else                         cnt_d   = cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          drain_d = 1'b0;
          state_d = S_DONE;
          cnt_d   = {ADDR_W{1'b0}};
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
        drain_d = 1'b0;
      end
    endcase

    // Early exit discards any read still in flight.
    if (STOP_ON_FAIL && mismatch_s) begin
      state_d     = S_DONE;
      cnt_d       = {ADDR_W{1'b0}};
      drain_d     = 1'b0;
      cmp_valid_d = 1'b0;
    end else begin
      cmp_valid_d = cmp_valid_d;
    end

    // Outputs are decoded from next state so the RAM sees them registered.
    we_a_d   = (state_d == S_W0);
    we_b_d   = (state_d == S_W1);
    addr_a_d = ((state_d == S_W0) || ((state_d == S_R1) && !drain_d)) ? cnt_d : {ADDR_W{1'b0}};
    addr_b_d = ((state_d == S_W1) || ((state_d == S_R0) && !drain_d)) ? cnt_d : {ADDR_W{1'b0}};
    din_a_d  = (state_d == S_W0) ? pat(cnt_d)  : {DATA_W{1'b0}};
    din_b_d  = (state_d == S_W1) ? ~pat(cnt_d) : {DATA_W{1'b0}};
    busy_d   = (state_d == S_W0) || (state_d == S_R0) || (state_d == S_W1) || (state_d == S_R1);
    done_d   = (state_d == S_DONE);
    pass_d   = done_d && (fail_count_d == 8'd0);
  end

  // State, compare pipeline, results and RAM-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= {ADDR_W{1'b0}};
      drain_q      <= 1'b0;
      cmp_valid_q  <= 1'b0;
      exp_addr_q   <= {ADDR_W{1'b0}};
      exp_inv_q    <= 1'b0;
      fail_count_q <= 8'd0;
      fail_addr_q  <= {ADDR_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      addr_a_q     <= {ADDR_W{1'b0}};
      addr_b_q     <= {ADDR_W{1'b0}};
      din_a_q      <= {DATA_W{1'b0}};
      din_b_q      <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      cmp_valid_q  <= cmp_valid_d;
      exp_addr_q   <= exp_addr_d;
      exp_inv_q    <= exp_inv_d;
      fail_count_q <= fail_count_d;
      fail_addr_q  <= fail_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      we_a_q       <= we_a_d;
      we_b_q       <= we_b_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      din_a_q      <= din_a_d;
      din_b_q      <= din_b_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;
  assign weA        = we_a_q;
  assign weB        = we_b_q;
  assign addrA      = addr_a_q;
  assign addrB      = addr_b_q;
  assign dinA       = din_a_q;
  assign dinB       = din_b_q;

endmodule

// File: tb/tb_tdp_march_bist.sv
// Bench for tdp_march_bist: behavioural dual-port RAM with injectable read
// faults, expected results queued per run and checked when done rises.
module tb_tdp_march_bist;

  localparam int DW = 256;
  localparam int AW = 4;
  localparam int DEPTH = 9;

`ifdef TDP_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, weA, weB;
  logic [AW-1:0] fail_addr, addrA, addrB;
  logic [7:0] fail_count;
  logic [DW-1:0] dinA, dinB, doutA, doutB;

  int total = 0;
  int bad = 0;
  int fault_mode = 0;

  typedef struct {
    logic       pass;
    logic [3:0] fa;
    logic [7:0] fc;
    int         blen;
  } exp_t;
  exp_t sb[$];

  tdp_march_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_count(fail_count),
    .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB),
    .dinA(dinA), .dinB(dinB), .doutA(doutA), .doutB(doutB)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {32{8'hA5}} ^ DW'(a);
  endfunction

  // Read-path fault: 1 = bit0 of word 3 stuck at 1, 2 = bit7 of every word flipped.
  function automatic logic [DW-1:0] fault(input logic [DW-1:0] d, input logic [AW-1:0] a, input int mode);
    logic [DW-1:0] r;
    r = d;
    if (mode == 1 && a == 4'd3) r[0] = 1'b1;
    if (mode == 2) r[7] = ~r[7];
    return r;
  endfunction

  // RAM model: registered address, both ports on clk.
  logic [DW-1:0] mem [16];
  logic [AW-1:0] ra_q = '0, rb_q = '0;
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (weA) mem[addrA] <= dinA;
    if (weB) mem[addrB] <= dinB;
    ra_q <= addrA;
    rb_q <= addrB;
  end
  assign doutA = fault(mem[ra_q], ra_q, fault_mode);
  assign doutB = fault(mem[rb_q], rb_q, fault_mode);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one march with the given fault mode.
  function automatic exp_t model(input int mode);
    exp_t e;
    logic [DW-1:0] want;
    e.pass = 1'b1; e.fa = 4'd0; e.fc = 8'd0; e.blen = 4*DEPTH + 2;
    for (int a = 0; a < DEPTH; a++) begin
      want = pat(4'(a));
      if (fault(want, 4'(a), mode) !== want) begin
        if (e.fc == 8'd0) e.fa = 4'(a);
        if (e.fc != 8'hFF) e.fc = e.fc + 8'd1;
        if (STOP) begin e.pass = 1'b0; e.blen = DEPTH + a + 2; return e; end
      end
    end
    for (int a = DEPTH-1; a >= 0; a--) begin
      want = ~pat(4'(a));
      if (fault(want, 4'(a), mode) !== want) begin
        if (e.fc == 8'd0) e.fa = 4'(a);
        if (e.fc != 8'hFF) e.fc = e.fc + 8'd1;
        if (STOP) begin e.pass = 1'b0; e.blen = 3*DEPTH + (DEPTH-1-a) + 3; return e; end
      end
    end
    e.pass = (e.fc == 8'd0);
    return e;
  endfunction

  // Protocol monitor: exclusive write enables, in-range write addresses, correct write data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_excl", DW'(weA & weB), DW'(1'b0));
      if (weA) begin
        chk("addrA_rng", DW'(addrA < AW'(DEPTH)), DW'(1'b1));
        chk("dinA_pat", dinA, pat(addrA));
      end
      if (weB) begin
        chk("addrB_rng", DW'(addrB < AW'(DEPTH)), DW'(1'b1));
        chk("dinB_pat", dinB, ~pat(addrB));
      end
    end
  end

  task automatic run(input int mode, input int extra_start);
    exp_t e;
    int blen, cyc;
    fault_mode = mode;
    sb.push_back(model(mode));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("done_clr", DW'(done), DW'(1'b0));
    blen = 0; cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) blen++;
      start = (cyc == extra_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("timeout", DW'(cyc < 200), DW'(1'b1));
    e = sb.pop_front();
    chk("busy_len", DW'(blen), DW'(e.blen));
    chk("busy_low", DW'(busy), DW'(1'b0));
    chk("pass", DW'(pass), DW'(e.pass));
    chk("fail_addr", DW'(fail_addr), DW'(e.fa));
    chk("fail_count", DW'(fail_count), DW'(e.fc));
    repeat (3) @(negedge clk);
    chk("done_sticky", DW'(done), DW'(1'b1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
    chk({tag, "_pass"}, DW'(pass), '0);
    chk({tag, "_fa"}, DW'(fail_addr), '0);
    chk({tag, "_fc"}, DW'(fail_count), '0);
    chk({tag, "_we"}, DW'({weA, weB}), '0);
    chk({tag, "_addr"}, DW'({addrA, addrB}), '0);
    chk({tag, "_dinA"}, dinA, '0);
    chk({tag, "_dinB"}, dinB, '0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    run(0, -1);      // clean RAM
    run(1, -1);      // stuck bit at word 3
    run(0, 10);      // start during run is ignored

    // Abort during R0, then a clean run from reset.
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_busy", DW'(busy), DW'(1'b1));
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_abort");
    run(0, -1);

    run(2, -1);      // every word corrupted
    run(0, -1);      // clean again: results cleared by start

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
